core_ctrl: RTL and testbench

Hardware instruction sequencer for the systolic-array `core`. It replaces the hand-driven instruction stream from the bench: it runs the full kij loop (weight SRAM→L0, L0→PE load, gap, activation SRAM→L0, execute), then drains the OFIFO with accumulate pulses. It sits between the host's start/done handshake and `core.inst[33:0]`. Array size, tile sizes and phase lengths are parameters.

---
 rtl/core_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_core_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_ctrl.sv
// Instruction sequencer for the systolic-array core: walks the kij loop
// (weights to L0, PE load, gap, activations to L0, execute) and then drains the OFIFO.
module core_ctrl #(
    parameter int row        = 8,
    parameter int col        = 8,
    parameter int len_kij    = 9,
    parameter int len_nij    = 36,
    parameter int len_onij   = 16,
    parameter int load_cyc   = col * len_kij,
    parameter int gap_cyc    = 11,
    parameter int exec_cyc   = (row + col) * len_nij + 10,
    parameter int act_base   = 0,
    parameter int w_base     = 1024,
    parameter int settle_cyc = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        busy,
    output logic        done,
    output logic [3:0]  kij_idx
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WL0,
        S_LOAD,
        S_GAP,
        S_AL0,
        S_EXEC,
        S_WAIT,
        S_PULSE,
        S_SETTLE,
        S_DONE
    } state_t;

    localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;
    localparam logic [15:0] W_LAST    = 16'(col);
    localparam logic [15:0] L_LAST    = 16'(load_cyc - 1);
    localparam logic [15:0] G_LAST    = 16'(gap_cyc - 1);
    localparam logic [15:0] A_LAST    = 16'(len_nij);
    localparam logic [15:0] E_LAST    = 16'(exec_cyc - 1);
    localparam logic [15:0] S_LAST    = 16'(settle_cyc);
    localparam logic [3:0]  KIJ_LAST  = 4'(len_kij - 1);
    localparam logic [7:0]  ONIJ      = 8'(len_onij);

    if (w_base + len_kij * col > 2048) begin : g_bad_wbase
        $error("core_ctrl: weight region exceeds the 11-bit xmem address space");
    end
    if (act_base + len_nij > w_base) begin : g_bad_actbase
        $error("core_ctrl: activation region overlaps the weight region");
    end
    if (load_cyc < 1 || gap_cyc < 1 || exec_cyc < 1 || len_kij < 1 || len_kij > 16 ||
        len_onij < 1 || len_onij > 255 || exec_cyc > 65535 || load_cyc > 65535) begin : g_bad_len
        $error("core_ctrl: phase length parameter out of range");
    end

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [3:0]  kij, kij_n;
    logic [7:0]  out, out_n;

    // The SRAM read for step t is issued at t, its L0 write lands at t+1, so
    // each streaming phase is one cycle longer than its word count.
    function automatic logic [33:0] encode(state_t s, logic [15:0] c, logic [3:0] k);
        logic [33:0] w;
        logic [10:0] a;
        w = IDLE_INST;
        a = '0;
        case (s)
            S_WL0: begin
                if (c < W_LAST) begin
                    a       = 11'(w_base + int'(k) * col + int'(c));
                    w[19]   = 1'b0;
                    w[17:7] = a;
                end
                if (c != 16'd0) w[2] = 1'b1;
            end
            S_AL0: begin
                if (c < A_LAST) begin
                    a       = 11'(act_base + int'(c));
                    w[19]   = 1'b0;
                    w[17:7] = a;
                end
                if (c != 16'd0) w[2] = 1'b1;
            end
            S_LOAD: begin
                w[3] = 1'b1;
                w[0] = 1'b1;
            end
            S_EXEC: begin
                w[3] = 1'b1;
                w[1] = 1'b1;
            end
            S_PULSE: begin
                w[33] = 1'b1;
                w[6]  = 1'b1;
            end
            default: ;
        endcase
        return w;
    endfunction

    // A drain slot opens on the edge after EXEC or after settle; valid seen then
    // issues the pulse immediately, otherwise we park in WAIT.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        kij_n   = kij;
        out_n   = out;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_WL0;
                    cnt_n   = '0;
                    kij_n   = '0;
                    out_n   = '0;
                end
            end
            S_WL0: begin
                if (cnt == W_LAST) begin
                    state_n = S_LOAD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_LOAD: begin
                if (cnt == L_LAST) begin
                    state_n = S_GAP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_GAP: begin
                if (cnt == G_LAST) begin
                    state_n = S_AL0;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_AL0: begin
                if (cnt == A_LAST) begin
                    state_n = S_EXEC;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_EXEC: begin
                if (cnt == E_LAST) begin
                    cnt_n = '0;
                    if (kij != KIJ_LAST) begin
                        kij_n   = kij + 4'd1;
                        state_n = S_WL0;
                    end else begin
                        out_n   = '0;
                        state_n = ofifo_valid ? S_PULSE : S_WAIT;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_WAIT: begin
                if (ofifo_valid) state_n = S_PULSE;
            end
            S_PULSE: begin
                state_n = S_SETTLE;
                cnt_n   = '0;
            end
            S_SETTLE: begin
                if (cnt == S_LAST) begin
                    cnt_n = '0;
                    out_n = out + 8'd1;
                    if (out + 8'd1 == ONIJ) state_n = S_DONE;
                    else state_n = ofifo_valid ? S_PULSE : S_WAIT;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                kij_n   = '0;
                out_n   = '0;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                kij_n   = '0;
                out_n   = '0;
            end
        endcase
    end

    // Outputs are encoded from the next state so inst lines up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            kij   <= '0;
            out   <= '0;
            inst  <= IDLE_INST;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            kij   <= kij_n;
            out   <= out_n;
            inst  <= encode(state_n, cnt_n, kij_n);
            busy  <= (state_n != S_IDLE) && (state_n != S_DONE);
            done  <= (state_n == S_DONE);
        end
    end

    assign kij_idx = kij;

endmodule

// File: tb/tb_core_ctrl.sv
// Self-checking bench for core_ctrl: a cycle-indexed reference of the whole run
// is compared against inst/busy/done/kij_idx every cycle, plus literal pins.
module tb_core_ctrl;

    localparam int COL        = 8;
    localparam int LEN_KIJ    = 9;
    localparam int LEN_NIJ    = 36;
    localparam int LEN_ONIJ   = 16;
    localparam int LOAD_CYC   = 72;
    localparam int GAP_CYC    = 11;
    localparam int EXEC_CYC   = 586;
    localparam int ACT_BASE   = 0;
    localparam int W_BASE     = 1024;
    localparam int SETTLE_CYC = 2;
    localparam int PER_KIJ    = (COL + 1) + LOAD_CYC + GAP_CYC + (LEN_NIJ + 1) + EXEC_CYC;
    localparam int KTOT       = LEN_KIJ * PER_KIJ;
    localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        busy;
    logic        done;
    logic [3:0]  kij_idx;

    core_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ofifo_valid(ofifo_valid),
        .inst       (inst),
        .busy       (busy),
        .done       (done),
        .kij_idx    (kij_idx)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int vmode  = 0;
    int vcyc   = 0;

    bit m_run = 1'b0;
    bit prev_valid = 1'b0;
    bit was_run, end_run;
    int m_n, m_pulses, m_ready, m_done_n;
    int mm, k, r, t;
    int load_cnt, exec_cnt, wr_cnt, overlap_cnt, pulse_cnt;
    logic [33:0] e_inst;
    logic        e_busy, e_done;
    int          e_kij;

    // Builds an instruction word from the core field map.
    function automatic logic [33:0] mk(bit cen, int addr, bit l0wr, bit l0rd, bit ex, bit ld, bit pulse);
        logic [10:0] a;
        a = 11'(addr);
        return {pulse, 1'b1, 1'b1, 11'd0, cen, 1'b1, a, pulse, 1'b0, 1'b0, l0rd, l0wr, ex, ld};
    endfunction

    task automatic check_field(string name, logic [33:0] act, logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ofifo_valid: 0, tied 1, or a one-cycle pulse every 20 cycles
    initial begin
        ofifo_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            vcyc++;
            ofifo_valid = (vmode == 1) || (vmode == 2 && (vcyc % 20) == 0);
        end
    end

    // Reference model and single compare point
    always @(negedge clk) begin
        if (reset) begin
            check_field("reset_inst", inst, IDLE_INST);
            check_field("reset_busy", {33'd0, busy}, 34'd0);
            check_field("reset_done", {33'd0, done}, 34'd0);
            check_field("reset_kij", {30'd0, kij_idx}, 34'd0);
            m_run      = 1'b0;
            prev_valid = ofifo_valid;
        end else begin
            was_run = m_run;
            end_run = 1'b0;
            e_inst  = IDLE_INST;
            e_busy  = 1'b0;
            e_done  = 1'b0;
            e_kij   = 0;
            if (m_run) begin
                e_busy = 1'b1;
                if (m_n <= KTOT) begin
                    mm    = m_n - 1;
                    k     = mm / PER_KIJ;
                    r     = mm % PER_KIJ;
                    e_kij = k;
                    if (r < COL + 1) begin
                        t = r;
                        if (t < COL) e_inst = mk(1'b0, W_BASE + k * COL + t, t >= 1, 0, 0, 0, 0);
                        else e_inst = mk(1'b1, 0, 1'b1, 0, 0, 0, 0);
                    end else if (r < COL + 1 + LOAD_CYC) begin
                        e_inst = mk(1'b1, 0, 0, 1, 0, 1, 0);
                    end else if (r < COL + 1 + LOAD_CYC + GAP_CYC) begin
                        e_inst = IDLE_INST;
                    end else if (r < COL + 1 + LOAD_CYC + GAP_CYC + LEN_NIJ + 1) begin
                        t = r - (COL + 1 + LOAD_CYC + GAP_CYC);
                        if (t < LEN_NIJ) e_inst = mk(1'b0, ACT_BASE + t, t >= 1, 0, 0, 0, 0);
                        else e_inst = mk(1'b1, 0, 1'b1, 0, 0, 0, 0);
                    end else begin
                        e_inst = mk(1'b1, 0, 0, 1, 1, 0, 0);
                    end
                end else begin
                    e_kij = LEN_KIJ - 1;
                    if (m_pulses == LEN_ONIJ && m_n == m_done_n) begin
                        e_done  = 1'b1;
                        e_busy  = 1'b0;
                        end_run = 1'b1;
                    end else if (m_pulses < LEN_ONIJ && m_n >= m_ready && prev_valid) begin
                        e_inst = mk(1'b1, 0, 0, 0, 0, 0, 1);
                        m_pulses++;
                        m_ready = m_n + SETTLE_CYC + 2;
                        if (m_pulses == LEN_ONIJ) m_done_n = m_n + SETTLE_CYC + 2;
                    end
                end
            end

            check_field("inst", inst, e_inst);
            check_field("busy", {33'd0, busy}, {33'd0, e_busy});
            check_field("done", {33'd0, done}, {33'd0, e_done});
            check_field("kij_idx", {30'd0, kij_idx}, 34'(e_kij));

            if (was_run) begin
                load_cnt    += int'(inst[0]);
                exec_cnt    += int'(inst[1]);
                wr_cnt      += int'(inst[2]);
                overlap_cnt += int'((inst[0] & inst[1]) | (inst[2] & inst[3]));
                pulse_cnt   += int'(inst[6] & inst[33]);
                case (m_n)
                    1:    check_field("pin_w0", inst, 34'h1_8006_0000);
                    2:    check_field("pin_w1", inst, 34'h1_8006_0084);
                    10:   check_field("pin_load", inst, 34'h1_800C_0009);
                    93:   check_field("pin_a0", inst, 34'h1_8004_0000);
                    128:  check_field("pin_a35", inst, 34'h1_8004_1184);
                    129:  check_field("pin_a_end", inst, 34'h1_800C_0004);
                    130:  check_field("pin_exec", inst, 34'h1_800C_000A);
                    5721: check_field("pin_k8_w0", inst, 34'h1_8006_2000);
                    5728: check_field("pin_k8_w7", inst, 34'h1_8006_2384);
                    default: ;
                endcase
                if (e_done && vmode == 1) check_field("done_latency", 34'(m_n), 34'd6500);
                if (end_run) begin
                    check_field("load_cycles", 34'(load_cnt), 34'd648);
                    check_field("exec_cycles", 34'(exec_cnt), 34'd5274);
                    check_field("l0_wr_cycles", 34'(wr_cnt), 34'd396);
                    check_field("overlap", 34'(overlap_cnt), 34'd0);
                    check_field("drain_pulses", 34'(pulse_cnt), 34'd16);
                end
            end

            if (end_run) m_run = 1'b0;
            else if (m_run) m_n++;
            if (!was_run && start) begin
                m_run       = 1'b1;
                m_n         = 1;
                m_pulses    = 0;
                m_ready     = KTOT + 1;
                m_done_n    = 0;
                load_cnt    = 0;
                exec_cnt    = 0;
                wr_cnt      = 0;
                overlap_cnt = 0;
                pulse_cnt   = 0;
            end
            prev_valid = ofifo_valid;
        end
    end

    task automatic apply_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20000 && m_run; i++) @(posedge clk);
        if (m_run) begin
            $display("[TB] FAIL run_timeout: got still running, expected run complete");
            $fatal(1, "[TB] run did not complete");
        end
        #1;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        vmode = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] run A: reset during EXEC of kij 4");
        apply_start();
        repeat (3189) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] run B: ofifo_valid tied high");
        vmode = 1;
        apply_start();
        wait_idle();
        repeat (3) @(posedge clk);

        $display("[TB] run C: ofifo_valid pulsed every 20 cycles");
        vmode = 2;
        apply_start();
        wait_idle();
        repeat (3) @(posedge clk);

        $display("[TB] run D: start reasserted during LOAD");
        vmode = 1;
        apply_start();
        repeat (19) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle();
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
